// File: rtl/legv8_fetch.sv
// LEGv8 instruction fetch stage: owns the PC, fetches words over a req/ack
// handshake and feeds the IF/ID register, with stall skid, redirect and drain.
module legv8_fetch #(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                if_id_valid,
    output logic [31:0]         if_id_inst,
    output logic [PC_WIDTH-1:0] if_id_pc,
    output logic [10:0]         opcode
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t              state;
    state_t              next_state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pending_pc;
    logic                skid_valid;
    logic [31:0]         skid_inst;
    logic [PC_WIDTH-1:0] skid_pc;
    logic                if_id_free;

    assign if_id_free = !stall || !if_id_valid;
    assign opcode     = if_id_inst[31:21];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: next_state = FETCH;
            FETCH: begin
                if (redirect_valid) begin
                    next_state = imem_ack ? FETCH : DRAIN;
                end else if (imem_ack && !if_id_free) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid || !stall) begin
                    next_state = FETCH;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    next_state = FETCH;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The PC stays put until the ack, so the address is stable for the whole
    // request; in DRAIN it is still the cancelled fetch's address.
    always_comb begin
        imem_req  = (state == FETCH) || (state == DRAIN);
        imem_addr = pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            pending_pc  <= RESET_PC;
            skid_valid  <= 1'b0;
            skid_inst   <= '0;
            skid_pc     <= '0;
            if_id_valid <= 1'b0;
            if_id_inst  <= '0;
            if_id_pc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        pc          <= redirect_pc;
                        if_id_valid <= 1'b0;
                        skid_valid  <= 1'b0;
                    end
                end
                FETCH: begin
                    if (redirect_valid) begin
                        if_id_valid <= 1'b0;
                        skid_valid  <= 1'b0;
                        if (imem_ack) begin
                            pc <= redirect_pc;
                        end else begin
                            pending_pc <= redirect_pc;
                        end
                    end else if (imem_ack) begin
                        pc <= pc + PC_WIDTH'(4);
                        if (if_id_free) begin
                            if_id_valid <= 1'b1;
                            if_id_inst  <= imem_rdata;
                            if_id_pc    <= pc;
                        end else begin
                            skid_valid <= 1'b1;
                            skid_inst  <= imem_rdata;
                            skid_pc    <= pc;
                        end
                    end else if (!stall) begin
                        if_id_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc          <= redirect_pc;
                        if_id_valid <= 1'b0;
                        skid_valid  <= 1'b0;
                    end else if (!stall) begin
                        if_id_valid <= skid_valid;
                        if_id_inst  <= skid_inst;
                        if_id_pc    <= skid_pc;
                        skid_valid  <= 1'b0;
                    end
                end
                DRAIN: begin
                    // A redirect arriving with the drained ack still wins.
                    if_id_valid <= 1'b0;
                    skid_valid  <= 1'b0;
                    if (imem_ack) begin
                        pc <= redirect_valid ? redirect_pc : pending_pc;
                    end else if (redirect_valid) begin
                        pending_pc <= redirect_pc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_legv8_fetch.sv
// Directed bench for legv8_fetch: walks the fetch stage through sequential
// fetch, wait states, stall/skid, redirect, drain and mid-drain reset.
module tb_legv8_fetch;

    localparam int PC_WIDTH = 64;

    logic                clk;
    logic                rst;
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic [31:0]         imem_rdata;
    logic                stall;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                if_id_valid;
    logic [31:0]         if_id_inst;
    logic [PC_WIDTH-1:0] if_id_pc;
    logic [10:0]         opcode;

    int checks;
    int failures;

    legv8_fetch #(.PC_WIDTH(PC_WIDTH), .RESET_PC('0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_inst     (if_id_inst),
        .if_id_pc       (if_id_pc),
        .opcode         (opcode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                                 input logic stl, input logic redir,
                                 input logic [PC_WIDTH-1:0] rpc);
        imem_ack       = ack;
        imem_rdata     = rdata;
        stall          = stl;
        redirect_valid = redir;
        redirect_pc    = rpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);

        #2;
        checkOutput("rst_req", {63'd0, imem_req}, 64'd0);
        checkOutput("rst_addr", imem_addr, 64'd0);
        checkOutput("rst_valid", {63'd0, if_id_valid}, 64'd0);
        checkOutput("rst_inst", {32'd0, if_id_inst}, 64'd0);
        checkOutput("rst_pc", if_id_pc, 64'd0);
        checkOutput("rst_opcode", {53'd0, opcode}, 64'd0);
        tick();
        tick();
        rst = 1'b1;

        // IDLE for one cycle, then zero-wait sequential fetch
        checkOutput("idle_req", {63'd0, imem_req}, 64'd0);
        tick();
        applyStimulus(1'b1, 32'h8B020020, 1'b0, 1'b0, '0);
        checkOutput("f0_req", {63'd0, imem_req}, 64'd1);
        checkOutput("f0_addr", imem_addr, 64'd0);
        checkOutput("f0_valid_pre", {63'd0, if_id_valid}, 64'd0);
        tick();
        checkOutput("f0_valid", {63'd0, if_id_valid}, 64'd1);
        checkOutput("f0_pc", if_id_pc, 64'd0);
        checkOutput("f0_inst", {32'd0, if_id_inst}, 64'h8B020020);
        checkOutput("f0_opcode", {53'd0, opcode}, 64'h458);
        checkOutput("f4_addr", imem_addr, 64'd4);
        applyStimulus(1'b1, 32'h8B030041, 1'b0, 1'b0, '0);
        tick();
        checkOutput("f4_pc", if_id_pc, 64'd4);
        checkOutput("f4_inst", {32'd0, if_id_inst}, 64'h8B030041);
        checkOutput("f4_opcode", {53'd0, opcode}, 64'h458);
        checkOutput("f8_addr", imem_addr, 64'd8);

        // Wait states on addr 8: address held, bubbles into IF/ID
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        tick();
        checkOutput("w1_req", {63'd0, imem_req}, 64'd1);
        checkOutput("w1_addr", imem_addr, 64'd8);
        checkOutput("w1_valid", {63'd0, if_id_valid}, 64'd0);
        tick();
        checkOutput("w2_addr", imem_addr, 64'd8);
        checkOutput("w2_valid", {63'd0, if_id_valid}, 64'd0);
        applyStimulus(1'b1, 32'hF84003E1, 1'b0, 1'b0, '0);
        tick();
        checkOutput("w3_valid", {63'd0, if_id_valid}, 64'd1);
        checkOutput("w3_pc", if_id_pc, 64'd8);
        checkOutput("w3_opcode", {53'd0, opcode}, 64'h7C2);
        checkOutput("f12_addr", imem_addr, 64'd12);

        // Stall while the ack for 12 arrives: word parks in the skid buffer
        applyStimulus(1'b1, 32'hB4000040, 1'b1, 1'b0, '0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0);
        checkOutput("hold_req", {63'd0, imem_req}, 64'd0);
        checkOutput("hold_pc", if_id_pc, 64'd8);
        checkOutput("hold_valid", {63'd0, if_id_valid}, 64'd1);
        tick();
        tick();
        checkOutput("hold3_req", {63'd0, imem_req}, 64'd0);
        checkOutput("hold3_pc", if_id_pc, 64'd8);
        checkOutput("hold3_inst", {32'd0, if_id_inst}, 64'hF84003E1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        tick();
        checkOutput("unstall_pc", if_id_pc, 64'd12);
        checkOutput("unstall_opcode", {53'd0, opcode}, 64'h5A0);
        checkOutput("unstall_valid", {63'd0, if_id_valid}, 64'd1);
        checkOutput("unstall_req", {63'd0, imem_req}, 64'd1);
        checkOutput("unstall_addr", imem_addr, 64'd16);

        // Redirect to 0x40 while fetch of 0x10 is unacked: drain it
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 64'h40);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        checkOutput("drain_req", {63'd0, imem_req}, 64'd1);
        checkOutput("drain_addr", imem_addr, 64'h10);
        checkOutput("drain_valid", {63'd0, if_id_valid}, 64'd0);
        tick();
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, '0);
        checkOutput("drain2_addr", imem_addr, 64'h10);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        checkOutput("postdrain_valid", {63'd0, if_id_valid}, 64'd0);
        checkOutput("postdrain_addr", imem_addr, 64'h40);
        checkOutput("postdrain_req", {63'd0, imem_req}, 64'd1);
        applyStimulus(1'b1, 32'h91000421, 1'b0, 1'b0, '0);
        tick();
        checkOutput("tgt_valid", {63'd0, if_id_valid}, 64'd1);
        checkOutput("tgt_pc", if_id_pc, 64'h40);
        checkOutput("tgt_opcode", {53'd0, opcode}, 64'h488);
        checkOutput("tgt_next_addr", imem_addr, 64'h44);

        // Redirect coincident with ack and stall: no HOLD, straight refetch
        applyStimulus(1'b1, 32'hAAAAAAAA, 1'b1, 1'b1, 64'h80);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        checkOutput("rda_valid", {63'd0, if_id_valid}, 64'd0);
        checkOutput("rda_req", {63'd0, imem_req}, 64'd1);
        checkOutput("rda_addr", imem_addr, 64'h80);
        applyStimulus(1'b1, 32'h8B020020, 1'b0, 1'b0, '0);
        tick();
        checkOutput("rda_tgt_pc", if_id_pc, 64'h80);
        checkOutput("rda_tgt_valid", {63'd0, if_id_valid}, 64'd1);

        // Reset asserted while in DRAIN; stray ack ignored
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 64'h100);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        checkOutput("pre_rst_req", {63'd0, imem_req}, 64'd1);
        checkOutput("pre_rst_addr", imem_addr, 64'h84);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_req", {63'd0, imem_req}, 64'd0);
        checkOutput("mid_rst_addr", imem_addr, 64'd0);
        checkOutput("mid_rst_valid", {63'd0, if_id_valid}, 64'd0);
        checkOutput("mid_rst_inst", {32'd0, if_id_inst}, 64'd0);
        checkOutput("mid_rst_pc", if_id_pc, 64'd0);
        checkOutput("mid_rst_opcode", {53'd0, opcode}, 64'd0);
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, '0);
        tick();
        rst = 1'b1;
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        checkOutput("restart_valid", {63'd0, if_id_valid}, 64'd0);
        checkOutput("restart_req", {63'd0, imem_req}, 64'd1);
        checkOutput("restart_addr", imem_addr, 64'd0);
        applyStimulus(1'b1, 32'h8B030041, 1'b0, 1'b0, '0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0);
        checkOutput("restart_pc", if_id_pc, 64'd0);
        checkOutput("restart_inst", {32'd0, if_id_inst}, 64'h8B030041);
        checkOutput("restart_next_addr", imem_addr, 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
